// File: rtl/i2c_pkg.sv
// Shared I2C definitions: decoder command codes, master FSM states and the
// per-quarter SCL/SDA waveform tables for each bus phase.
package i2c_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t I2C_NOP     = 3'b000;
    localparam cmd_t I2C_START   = 3'b001;
    localparam cmd_t I2C_STOP    = 3'b010;
    localparam cmd_t I2C_SENDCON = 3'b011;
    localparam cmd_t I2C_SENDI2C = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP
    } state_t;

    typedef logic [1:0] quarter_t;

    localparam quarter_t Q_LAST = 2'd3;

    // Codes 101-111 are reserved and behave as NOP.
    function automatic logic is_cmd(input cmd_t c);
        return (c != I2C_NOP) && (c <= I2C_SENDI2C);
    endfunction

    function automatic logic scl_level(input state_t s, input quarter_t q);
        logic lvl;
        lvl = 1'b1;
        case (s)
            START:   lvl = (q <= 2'd1);
            BIT,
            ACK:     lvl = (q == 2'd1) || (q == 2'd2);
            STOP:    lvl = (q != 2'd0);
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

    // Data is stable across the whole bit cell; START/STOP edges fall
    // inside the SCL-high quarters.
    function automatic logic sda_level(input state_t s, input quarter_t q,
                                       input logic bit_val);
        logic lvl;
        lvl = 1'b1;
        case (s)
            START:   lvl = (q == 2'd0);
            BIT:     lvl = bit_val;
            ACK:     lvl = 1'b1;
            STOP:    lvl = (q >= 2'd2);
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/i2c_master_if.sv
// Command/bus bundle between the instruction decoder, the I2C master and
// the OLED panel lines.
interface i2c_master_if;
    import i2c_pkg::*;

    cmd_t       i_i2c_ctrl;
    logic [7:0] i_data;
    logic       i_sda;
    logic       o_scl;
    logic       o_sda;
    logic       o_busy;
    logic       o_done;
    logic       o_ack_err;

    modport master (
        input  i_i2c_ctrl,
        input  i_data,
        input  i_sda,
        output o_scl,
        output o_sda,
        output o_busy,
        output o_done,
        output o_ack_err
    );

    modport slave (
        output i_i2c_ctrl,
        output i_data,
        output i_sda,
        input  o_scl,
        input  o_sda,
        input  o_busy,
        input  o_done,
        input  o_ack_err
    );

endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-period timebase: o_qtick is high on the last clock of every
// CLK_DIV-clock quarter; restart realigns the count to a new command.
module i2c_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic restart,
    output logic o_qtick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign o_qtick = (cnt == LAST);

endmodule

// File: rtl/i2c_master.sv
// Write-only byte-level I2C master for the OLED panel. Define
// I2C_ACK_CHECK_EN to sample the slave ACK and drive the sticky o_ack_err.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV    = 125,
    parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    i2c_master_if.master bus
);

    state_t     state, state_nx;
    quarter_t   q, q_nx;
    logic [2:0] bit_idx, bit_nx;
    logic [7:0] shreg, shreg_nx;
    logic       scl, scl_nx;
    logic       sda, sda_nx;
    logic       done, done_nx;
    logic       restart;
    logic       qtick;
    logic       ack_sample;
    logic       ack_clr;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .restart (restart),
        .o_qtick (qtick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            q       <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            scl     <= 1'b1;
            sda     <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            q       <= q_nx;
            bit_idx <= bit_nx;
            shreg   <= shreg_nx;
            scl     <= scl_nx;
            sda     <= sda_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        q_nx       = q;
        bit_nx     = bit_idx;
        shreg_nx   = shreg;
        done_nx    = 1'b0;
        restart    = 1'b0;
        ack_sample = 1'b0;
        ack_clr    = 1'b0;
        scl_nx     = scl;
        sda_nx     = sda;

        case (state)
            IDLE: begin
                if (is_cmd(bus.i_i2c_ctrl)) begin
                    restart = 1'b1;
                    q_nx    = '0;
                    bit_nx  = '0;
                    case (bus.i_i2c_ctrl)
                        I2C_START: begin
                            state_nx = START;
                            ack_clr  = 1'b1;
                        end
                        I2C_STOP: state_nx = STOP;
                        I2C_SENDCON: begin
                            state_nx = BIT;
                            shreg_nx = {SLAVE_ADDR, 1'b0};
                        end
                        I2C_SENDI2C: begin
                            state_nx = BIT;
                            shreg_nx = bus.i_data;
                        end
                        default: state_nx = IDLE;
                    endcase
                end
            end
            BIT: begin
                if (qtick) begin
                    if (q == Q_LAST) begin
                        q_nx = '0;
                        if (bit_idx == 3'd7) begin
                            state_nx = ACK;
                        end else begin
                            bit_nx = bit_idx + 3'd1;
                        end
                    end else begin
                        q_nx = q + 2'd1;
                    end
                end
            end
            START, STOP, ACK: begin
                // The slave's ACK is stable by the end of the first SCL-high quarter.
                ack_sample = (state == ACK) && qtick && (q == 2'd1);
                if (qtick) begin
                    if (q == Q_LAST) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        q_nx = q + 2'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Lines are registered from the next phase so they change together
        // with the state; IDLE keeps whatever the last command left on the bus.
        if (state_nx != IDLE) begin
            scl_nx = scl_level(state_nx, q_nx);
            sda_nx = sda_level(state_nx, q_nx, shreg_nx[3'd7 - bit_nx]);
        end
    end

`ifdef I2C_ACK_CHECK_EN
    logic ack_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_err <= 1'b0;
        end else if (ack_clr) begin
            ack_err <= 1'b0;
        end else if (ack_sample && bus.i_sda) begin
            ack_err <= 1'b1;
        end
    end

    assign bus.o_ack_err = ack_err;
`else
    logic unused_ack;
    assign unused_ack    = ^{ack_sample, ack_clr, bus.i_sda};
    assign bus.o_ack_err = 1'b0;
`endif

    assign bus.o_scl  = scl;
    assign bus.o_sda  = sda;
    assign bus.o_busy = (state != IDLE);
    assign bus.o_done = done;

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master (CLK_DIV=4): the driver queues the
// expected bus transaction per command, the monitor checks it at o_done.
module tb_i2c_master;
    import i2c_pkg::*;

    typedef struct {
        int         busy;
        int         nbits;
        logic [8:0] bits;
        logic       st;
        logic       sp;
        logic       ack;
    } exp_t;

`ifdef I2C_ACK_CHECK_EN
    localparam logic ACK_EXP = 1'b1;
`else
    localparam logic ACK_EXP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    i2c_master_if bus();

    i2c_master #(
        .CLK_DIV    (4),
        .SLAVE_ADDR (7'h3C)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor state: events observed on the lines since the last o_done.
    logic       prev_scl, prev_sda;
    logic       st_seen, sp_seen;
    int         nbits, busy_cnt;
    logic [8:0] bits;

    function automatic void clear_obs();
        st_seen  = 1'b0;
        sp_seen  = 1'b0;
        nbits    = 0;
        busy_cnt = 0;
        bits     = '0;
    endfunction

    initial begin
        exp_t e;
        clear_obs();
        prev_scl = 1'b1;
        prev_sda = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_scl === 1'b1 && bus.o_scl === 1'b1) begin
                if (prev_sda === 1'b1 && bus.o_sda === 1'b0) st_seen = 1'b1;
                if (prev_sda === 1'b0 && bus.o_sda === 1'b1) sp_seen = 1'b1;
            end
            if (prev_scl === 1'b0 && bus.o_scl === 1'b1) begin
                bits = {bits[7:0], bus.o_sda};
                nbits++;
            end
            if (bus.o_busy === 1'b1) busy_cnt++;
            if (!rst_n) begin
                clear_obs();
            end else if (bus.o_done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending command");
                end else begin
                    e = sb.pop_front();
                    check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                    check("done_busy_low", 32'(bus.o_busy), 32'(0));
                    check("scl_high_bits", 32'(nbits), 32'(e.nbits));
                    check("sda_bits", 32'(bits), 32'(e.bits));
                    check("start_cond", 32'(st_seen), 32'(e.st));
                    check("stop_cond", 32'(sp_seen), 32'(e.sp));
                    check("ack_err", 32'(bus.o_ack_err), 32'(e.ack));
                end
                clear_obs();
            end
            prev_scl = bus.o_scl;
            prev_sda = bus.o_sda;
        end
    end

    task automatic send(input cmd_t c, input logic [7:0] d);
        @(negedge clk);
        bus.i_i2c_ctrl = c;
        bus.i_data     = d;
        @(negedge clk);
        bus.i_i2c_ctrl = I2C_NOP;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.o_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no o_done expected o_done within 400 cycles", name);
        end
    endtask

    task automatic issue(input string name, input cmd_t c, input logic [7:0] d, input exp_t e);
        sb.push_back(e);
        send(c, d);
        wait_done(name);
    endtask

    initial begin
        exp_t e_start, e_stop, e_con, e_dat;
        e_start = '{busy: 16,  nbits: 0, bits: 9'h000, st: 1'b1, sp: 1'b0, ack: 1'b0};
        e_con   = '{busy: 144, nbits: 9, bits: 9'h0F1, st: 1'b0, sp: 1'b0, ack: 1'b0};
        e_dat   = '{busy: 144, nbits: 9, bits: 9'h14B, st: 1'b0, sp: 1'b0, ack: ACK_EXP};
        e_stop  = '{busy: 16,  nbits: 1, bits: 9'h000, st: 1'b0, sp: 1'b1, ack: ACK_EXP};

        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        bus.i_i2c_ctrl = I2C_NOP;
        bus.i_data     = 8'h00;
        bus.i_sda      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(bus.o_scl), 32'(1));
        check("rst_sda", 32'(bus.o_sda), 32'(1));
        check("rst_busy", 32'(bus.o_busy), 32'(0));
        check("rst_done", 32'(bus.o_done), 32'(0));
        check("rst_ack_err", 32'(bus.o_ack_err), 32'(0));
        rst_n = 1'b1;

        issue("start", I2C_START, 8'h00, e_start);
        bus.i_sda = 1'b0;
        issue("sendcon", I2C_SENDCON, 8'hFF, e_con);
        bus.i_sda = 1'b1;
        issue("sendi2c_a5", I2C_SENDI2C, 8'hA5, e_dat);
        issue("stop", I2C_STOP, 8'h00, e_stop);

        repeat (10) @(negedge clk);
        check("idle_scl", 32'(bus.o_scl), 32'(1));
        check("idle_sda", 32'(bus.o_sda), 32'(1));

        // Reserved code in IDLE must not start anything.
        bus.i_i2c_ctrl = 3'b111;
        repeat (20) @(negedge clk);
        check("nop7_busy", 32'(bus.o_busy), 32'(0));
        check("nop7_scl", 32'(bus.o_scl), 32'(1));
        check("nop7_sda", 32'(bus.o_sda), 32'(1));
        bus.i_i2c_ctrl = I2C_NOP;

        // SENDI2C presented while START is running must be ignored.
        sb.push_back(e_start);
        send(I2C_START, 8'h00);
        repeat (2) @(negedge clk);
        bus.i_i2c_ctrl = I2C_SENDI2C;
        bus.i_data     = 8'h3C;
        repeat (8) @(negedge clk);
        bus.i_i2c_ctrl = I2C_NOP;
        wait_done("start_busy_ignore");
        repeat (30) @(negedge clk);
        check("ignored_busy", 32'(bus.o_busy), 32'(0));

        // Reset in the middle of bit 3 of a byte.
        send(I2C_SENDI2C, 8'h5A);
        repeat (52) @(negedge clk);
        check("mid_byte_busy", 32'(bus.o_busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_scl", 32'(bus.o_scl), 32'(1));
        check("async_rst_sda", 32'(bus.o_sda), 32'(1));
        check("async_rst_busy", 32'(bus.o_busy), 32'(0));
        repeat (3) @(negedge clk);
        check("rst_no_done", 32'(bus.o_done), 32'(0));
        rst_n = 1'b1;

        issue("start_after_rst", I2C_START, 8'h00, e_start);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_master.md
# i2c_master

Byte-level I2C master that executes the bus commands issued by the instruction decoder (`I2CSTART`, `I2CSTOP`, `SENDCON`, `SENDI2C`) and drives the OLED panel's SCL/SDA lines. It sits directly downstream of the decoder's 3-bit I2C control output. It accepts one command at a time, signals `o_busy` so the core stalls, and pulses `o_done` on completion. The block is write-only: no read transfers.

## Interface
- `CLK_DIV`, 125: system clocks per SCL quarter-period (≥2).
- `SLAVE_ADDR`, 7'h3C: 7-bit device address sent by `SENDCON`.

- `i_clk`, in, 1: system clock, rising edge.
- `i_rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `i_i2c_ctrl`, in, 3: command. 000 NOP, 001 START, 010 STOP, 011 SENDCON, 100 SENDI2C; 101–111 are treated as NOP.
- `i_data`, in, 8: byte sent by `SENDI2C`.
- `i_sda`, in, 1: sampled SDA line, used for ACK.
- `o_scl`, out, 1: SCL drive. 1 means released.
- `o_sda`, out, 1: SDA drive. 1 means released/high.
- `o_busy`, out, 1: command in progress.
- `o_done`, out, 1: one-cycle completion pulse.
- `o_ack_err`, out, 1: sticky NACK flag.

## Operation
- States: `IDLE`, `START`, `BIT`, `ACK`, `STOP`.
- A command is accepted only in `IDLE` when `i_i2c_ctrl` is non-zero. Commands presented while busy are ignored; the core must hold the instruction until it sees `o_done`.
- On acceptance, the shift register loads:
  - `SENDCON`: `{SLAVE_ADDR,1'b0}`.
  - `SENDI2C`: `i_data`.
  - The loaded value is frozen for the rest of the command.
- Each state lasts a whole number of quarters. A quarter is `CLK_DIV` clocks, produced by the tick generator. The counter restarts at acceptance.
- `START` (4 quarters), SCL/SDA per quarter: 1/1, 1/0, 0/0, 0/0. If a previous START was not followed by STOP, this is a repeated start.
- `BIT`: 8 bits, MSB first, 4 quarters per bit.
  - q0: SCL=0, SDA=bit.
  - q1–q2: SCL=1.
  - q3: SCL=0.
- `ACK` (4 quarters): SDA released (1); SCL same pattern as `BIT`. `i_sda` is sampled on the last clock of q1. Sampled 1 sets `o_ack_err`. The transfer still completes.
- `STOP` (4 quarters), SCL/SDA per quarter: 0/0, 1/0, 1/1, 1/1.
- `o_ack_err` is cleared only by reset, or by acceptance of a START.
- Reset values: `o_scl`=1, `o_sda`=1, `o_busy`=0, `o_done`=0, `o_ack_err`=0, state `IDLE`.

## Timing
- Command sampled at edge k: `o_busy`=1 from k+1. Line changes begin at k+1.
- Duration, from k+1 to `o_done`:
  - START/STOP: 4·CLK_DIV clocks.
  - SENDCON/SENDI2C: 36·CLK_DIV clocks.
- On the cycle after the final quarter, `o_done`=1 and `o_busy`=0 in the same cycle. A new command may be accepted on that same edge.
- Reset mid-command: immediate return to `IDLE` with both lines released. No STOP is emitted; software reissues START.

## Configuration
- `I2C_ACK_CHECK_EN` defined: ACK sampled as described and `o_ack_err` is live.
- Not defined: the ACK slot is still clocked (9 SCL pulses per byte), but `i_sda` is ignored and `o_ack_err` is tied to 0.

## Structure
- Package `i2c_pkg`:
  - command encodings (`I2C_NOP`, `I2C_START`, `I2C_STOP`, `I2C_SENDCON`, `I2C_SENDI2C`), shared with the decoder.
  - state enum.
  - quarter index type.
- Sub-module `i2c_tick_gen`: `CLK_DIV` counter. Restarts on a `restart` input and emits a one-cycle `o_qtick` at the end of each quarter.

## Test plan
All scenarios use CLK_DIV=4, SLAVE_ADDR=7'h3C.
- Reset, then START → `o_sda` falls while `o_scl`=1; `o_done` 16 clocks after k+1; `o_busy` high for exactly 16 cycles.
- SENDCON, slave ACKs (`i_sda`=0) → SDA on SCL highs is 0,1,1,1,1,0,0,0, then released; `o_done` at +144; `o_ack_err`=0.
- SENDI2C with `i_data`=8'hA5, `i_sda` held 1 → bits 1,0,1,0,0,1,0,1; `o_ack_err`=1 (0 when `I2C_ACK_CHECK_EN` is undefined); flag stays set through a following STOP.
- STOP → SDA rises while SCL=1; then both lines stay 1 in `IDLE`.
- SENDI2C issued while busy, and code 3'b111 issued in `IDLE` → both ignored; no line activity; no `o_done`.
- `i_rst_n` asserted at bit 3 of a byte → `o_scl`=`o_sda`=1 and `o_busy`=0 asynchronously; the next START proceeds normally.
